pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 128 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter and instruction-fetch control.
// Issues instruction-memory reads at pc, captures returned words, honours
// downstream stall, redirects on taken branches and latches a sticky error on
// a misaligned branch target (left only through reset).
`timescale 1ns/1ps

module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic branch_ok;
  logic branch_bad;
  logic capture;

  // A branch is only legal when the target is word aligned; the branch wins
  // over any memory acknowledge arriving in the same cycle.
  assign branch_ok  = branch_taken && (branch_target[1:0] == 2'b00);
  assign branch_bad = branch_taken && (branch_target[1:0] != 2'b00);
  assign capture    = (state == REQ) && imem_ack && !branch_taken;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection; ERR is absorbing until reset.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (branch_bad) next_state = ERR;
        else            next_state = REQ;
      end
      REQ: begin
        if (branch_bad)      next_state = ERR;
        else if (branch_ok)  next_state = REQ;
        else if (imem_ack)   next_state = stall ? HOLD : REQ;
        else                 next_state = REQ;
      end
      HOLD: begin
        if (branch_bad)      next_state = ERR;
        else if (branch_ok)  next_state = REQ;
        else                 next_state = stall ? HOLD : REQ;
      end
      ERR: begin
        next_state = ERR;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Memory request outputs decoded from the registered state and pc.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    case (state)
      REQ:     imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  // Datapath: pc, captured instruction and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      instr_valid  <= 1'b0;
      instr        <= 32'h00000000;
      instr_pc     <= 32'h00000000;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        ERR: begin
          instr_valid <= 1'b0;
        end
        default: begin
          if (branch_bad) begin
            misalign_err <= 1'b1;
            instr_valid  <= 1'b0;
          end else if (branch_ok) begin
            pc          <= branch_target;
            instr_valid <= 1'b0;
          end else if (capture) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc_plus4;
          end else begin
            // An unconsumed instruction stays presented while stalled.
            instr_valid <= instr_valid & stall;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios followed by randomized traffic. The
// stimulus process runs a transaction-level reference model and pushes the
// expected per-cycle outputs into a scoreboard queue; a monitor pops and
// compares on every falling edge.
`timescale 1ns/1ps

module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign_err;

  always #5 clk = ~clk;

  // Behaviour of the external +4 adder.
  assign pc_plus4 = pc + 32'd4;

  pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_plus4(pc_plus4),
    .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .misalign_err(misalign_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        req;
    logic        valid;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model (transaction view): the pc being fetched, the word
  // currently presented downstream, whether fetching is paused behind a
  // stalled word, the one dead cycle after reset, and the sticky error.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  bit          m_valid;
  bit          m_boot;
  bit          m_hold;
  bit          m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = 32'h0; m_ipc = 32'h0;
    m_valid = 1'b0; m_boot = 1'b1; m_hold = 1'b0; m_err = 1'b0;
  endtask

  // One clock cycle: drive inputs, record what the DUT must show now, then
  // advance the model by the events applied at the coming edge.
  task automatic cycle(input bit r, input bit br, input logic [31:0] tgt,
                       input bit st, input bit ak, input logic [31:0] rd);
    exp_t e;
    bit   fetching;
    rst = r; branch_taken = br; branch_target = tgt;
    stall = st; imem_ack = ak; imem_rdata = rd;
    fetching = !m_err && !m_boot && !m_hold;
    e.pc = m_pc; e.instr = m_instr; e.ipc = m_ipc;
    e.req = fetching; e.valid = m_valid; e.err = m_err;
    sbq.push_back(e);
    if (r) begin
      model_reset();
    end else if (m_err) begin
      m_valid = 1'b0;
    end else if (br) begin
      m_valid = 1'b0;
      if (tgt[1:0] != 2'b00) begin
        m_err = 1'b1;
      end else begin
        m_pc = tgt; m_boot = 1'b0; m_hold = 1'b0;
      end
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_hold) begin
      m_valid = m_valid && st;
      m_hold  = st;
    end else if (ak) begin
      m_instr = rd; m_ipc = m_pc; m_valid = 1'b1;
      m_pc = m_pc + 32'd4; m_hold = st;
    end else begin
      m_valid = m_valid && st;
    end
    @(posedge clk); #1;
  endtask

  // Monitor: compares DUT outputs against the oldest expected record.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("pc", pc, e.pc);
        chk("imem_req", {31'd0, imem_req}, {31'd0, e.req});
        if (e.req) chk("imem_addr", imem_addr, e.pc);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, e.valid});
        chk("instr", instr, e.instr);
        chk("instr_pc", instr_pc, e.ipc);
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    bit          br;
    // Bring the DUT out of its unknown power-up state before checking.
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();

    // Reset state, then continuous fetch with ack tied high from 0.
    cycle(1, 0, 32'h0, 0, 1, 32'hDEAD0000);
    for (int i = 0; i < 6; i++) cycle(0, 0, 32'h0, 0, 1, $urandom);

    // Delayed acknowledge at 0x10.
    cycle(0, 1, 32'h10, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 32'h0, 0, 0, $urandom);
    cycle(0, 0, 32'h0, 0, 1, 32'h11111111);
    cycle(0, 0, 32'h0, 0, 0, 32'h0);

    // Stalled capture at 0x20, stray acks during HOLD must be ignored.
    cycle(0, 1, 32'h20, 0, 0, 32'h0);
    cycle(0, 0, 32'h0, 1, 1, 32'h22222222);
    cycle(0, 0, 32'h0, 1, 1, $urandom);
    cycle(0, 0, 32'h0, 0, 1, $urandom);
    for (int i = 0; i < 3; i++) cycle(0, 0, 32'h0, 0, 1, $urandom);

    // Branch beats a same-cycle ack at 0x30.
    cycle(0, 1, 32'h30, 0, 0, 32'h0);
    cycle(0, 1, 32'h100, 0, 1, 32'h33333333);
    for (int i = 0; i < 3; i++) cycle(0, 0, 32'h0, 0, 1, $urandom);

    // Misaligned branch: error is sticky and everything else is ignored.
    cycle(0, 1, 32'h102, 0, 1, 32'h0);
    for (int i = 0; i < 6; i++) cycle(0, $urandom_range(1, 0), 32'h200, 0, 1, $urandom);
    cycle(1, 0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 32'h0, 0, 1, $urandom);

    // Address wrap from the top of memory.
    cycle(0, 1, 32'hFFFFFFFC, 0, 0, 32'h0);
    cycle(0, 0, 32'h0, 0, 1, 32'h44444444);
    for (int i = 0; i < 2; i++) cycle(0, 0, 32'h0, 0, 1, $urandom);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      br  = ($urandom_range(11, 0) == 0);
      tgt = $urandom & 32'hFFFFFFFC;
      if ($urandom_range(39, 0) == 0) tgt[1:0] = 2'($urandom_range(3, 1));
      cycle((m_err && $urandom_range(7, 0) == 0) || $urandom_range(299, 0) == 0,
            br, tgt, ($urandom_range(2, 0) == 0), ($urandom_range(2, 0) != 0), $urandom);
    end

    cycle(0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk); #1;
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
